// File: rtl/avl_bus_ram_slave_if.sv
// avl_bus interface: master-side request stream plus the read-response return path.
`ifndef ALV_BURST_MAX_COUNT
`define ALV_BURST_MAX_COUNT 15
`endif

interface i_avl_bus #(
  parameter int unsigned BURST_W = $clog2(`ALV_BURST_MAX_COUNT + 1)
);
  logic [31:0]        address;
  logic [3:0]         byte_en;
  logic               read;
  logic               write;
  logic [31:0]        write_data;
  logic               begin_burst_transfer;
  logic [BURST_W-1:0] burst_count;
  logic               request_ready;
  logic [31:0]        read_data;
  logic               read_data_valid;
  logic               resp_ready;

  modport slave (
    input  address, byte_en, read, write, write_data,
    input  begin_burst_transfer, burst_count, resp_ready,
    output request_ready, read_data, read_data_valid
  );

  modport master (
    output address, byte_en, read, write, write_data,
    output begin_burst_transfer, burst_count, resp_ready,
    input  request_ready, read_data, read_data_valid
  );
endinterface

// File: rtl/avl_bus_ram_slave.sv
// On-chip RAM slave for avl_bus: byte-enabled writes, credit-limited read-response FIFO,
// and a burst sequencing checker that pulses protocol_err on violations.
`ifndef ALV_BURST_MAX_COUNT
`define ALV_BURST_MAX_COUNT 15
`endif

module avl_bus_ram_slave #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned RESP_FIFO_DEPTH = 4,
  parameter int unsigned BURST_MAX       = `ALV_BURST_MAX_COUNT
) (
  input  logic    clk,
  input  logic    rest,
  i_avl_bus.slave avl_s,
  output logic    protocol_err
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(RESP_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, BURST} state_e;

  logic [31:0]   mem_q [MEM_WORDS];
  logic [31:0]   rdata_q;
  logic          rd_pend_q;
  logic [31:0]   fifo_q [RESP_FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] credits_q, credits_d;

  state_e        state_q, state_d;
  logic [BW-1:0] rem_q, rem_d;
  logic [31:0]   exp_q, exp_d;
  logic          kind_q, kind_d;
  logic          err_q, err_d;

  logic          ready_c, acc_c, acc_rd_c, acc_wr_c, pop_c, start_c, beat_ok_c;
  logic [AW-1:0] widx_c;
  logic [BW-1:0] bc_c;

  // Readiness depends only on the credit register, never on the current strobes.
  assign ready_c   = (credits_q < CW'(RESP_FIFO_DEPTH));
  assign acc_c     = (avl_s.read | avl_s.write) & ready_c;
  assign acc_wr_c  = acc_c & avl_s.write;
  assign acc_rd_c  = acc_c & avl_s.read & ~avl_s.write;
  assign pop_c     = avl_s.resp_ready & (cnt_q != '0);
  assign widx_c    = avl_s.address[AW+1:2];
  assign bc_c      = BW'(avl_s.burst_count);
  assign start_c   = avl_s.begin_burst_transfer & (bc_c != '0);
  assign beat_ok_c = ~avl_s.begin_burst_transfer & (kind_q == avl_s.write) &
                     (avl_s.address == exp_q) & (bc_c == rem_q - BW'(1));

  assign credits_d = credits_q + CW'(acc_rd_c) - CW'(pop_c);
  assign cnt_d     = cnt_q + CW'(rd_pend_q) - CW'(pop_c);

  // RAM array and read stage carry no reset so contents survive rest.
  always_ff @(posedge clk) begin
    if (acc_wr_c) begin
      for (int i = 0; i < 4; i++) begin
        if (avl_s.byte_en[i]) mem_q[widx_c][8*i +: 8] <= avl_s.write_data[8*i +: 8];
      end
    end
    if (acc_rd_c) rdata_q <= mem_q[widx_c];
  end

  // Burst sequencing: restart on a fresh burst header, otherwise validate the beat.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    exp_d   = exp_q;
    kind_d  = kind_q;
    err_d   = 1'b0;
    if (acc_c) begin
      if (avl_s.read && avl_s.write) err_d = 1'b1;
      if (state_q == BURST && beat_ok_c) begin
        rem_d = rem_q - BW'(1);
        exp_d = exp_q + 32'd4;
        if (rem_q == BW'(1)) state_d = IDLE;
      end else begin
        if (state_q == BURST) err_d = 1'b1;
        if (start_c) begin
          state_d = BURST;
          rem_d   = bc_c;
          exp_d   = avl_s.address + 32'd4;
          kind_d  = avl_s.write;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      exp_q     <= '0;
      kind_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      credits_q <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      for (int i = 0; i < RESP_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      exp_q     <= exp_d;
      kind_q    <= kind_d;
      err_q     <= err_d;
      rd_pend_q <= acc_rd_c;
      credits_q <= credits_d;
      cnt_q     <= cnt_d;
      if (rd_pend_q) begin
        fifo_q[wptr_q] <= rdata_q;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop_c) rptr_q <= rptr_q + PW'(1);
    end
  end

  assign avl_s.request_ready   = ready_c;
  assign avl_s.read_data       = fifo_q[rptr_q];
  assign avl_s.read_data_valid = (cnt_q != '0);
  assign protocol_err          = err_q;

endmodule

// File: tb/tb_avl_bus_ram_slave.sv
// Scoreboard bench for avl_bus_ram_slave: directed requests push expected read data,
// a negedge monitor pops and compares every response the master consumes.
`ifndef ALV_BURST_MAX_COUNT
`define ALV_BURST_MAX_COUNT 15
`endif

module tb_avl_bus_ram_slave;
  localparam int unsigned BW = $clog2(`ALV_BURST_MAX_COUNT + 1);

  logic clk = 1'b0;
  logic rest = 1'b1;
  logic protocol_err;

  i_avl_bus bus ();

  avl_bus_ram_slave #(.MEM_WORDS(1024), .RESP_FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rest         (rest),
    .avl_s        (bus),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor and protocol_err pulse counter.
  always @(negedge clk) begin
    if (rest && protocol_err) err_seen++;
    if (rest && bus.read_data_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got 0x%08h expected no response", bus.read_data);
      end else begin
        chk("resp_data", bus.read_data, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd, input logic bbt,
                     input logic [BW-1:0] bc, input logic [31:0] exp_rd);
    logic rdy;
    int   n;
    bus.read = rd;
    bus.write = wr;
    bus.address = addr;
    bus.byte_en = be;
    bus.write_data = wd;
    bus.begin_burst_transfer = bbt;
    bus.burst_count = bc;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = bus.request_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: addr 0x%08h got no accept expected accept", addr);
    end else if (rd && !wr) begin
      exp_q.push_back(exp_rd);
    end
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.begin_burst_transfer = 1'b0;
    bus.burst_count = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d,
                    input logic bbt, input logic [BW-1:0] bc);
    req(1'b0, 1'b1, addr, be, d, bbt, bc, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd);
    req(1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b0, '0, exp_rd);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  accepted;
    logic rdy;
    bus.address = '0;
    bus.byte_en = '0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.write_data = '0;
    bus.begin_burst_transfer = 1'b0;
    bus.burst_count = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    #1 rest = 1'b0;
    #2;
    chk("rst_valid", 32'(bus.read_data_valid), 32'd0);
    chk("rst_ready", 32'(bus.request_ready), 32'd1);
    chk("rst_data", bus.read_data, 32'h0);
    chk("rst_err", 32'(protocol_err), 32'd0);
    @(negedge clk) rest = 1'b1;
    @(posedge clk) #1;

    // Basic write/read and one-cycle read latency
    wr(32'h10, 4'hF, 32'hDEADBEEF, 1'b0, '0);
    rd(32'h10, 32'hDEADBEEF);
    @(negedge clk) chk("lat_not_yet", 32'(bus.read_data_valid), 32'd0);
    @(negedge clk) chk("lat_valid", 32'(bus.read_data_valid), 32'd1);
    @(posedge clk) #1;

    // Byte lanes, aliasing, read-after-write, read&write collision
    wr(32'h20, 4'hF, 32'h11223344, 1'b0, '0);
    wr(32'h20, 4'h3, 32'hAABBCCDD, 1'b0, '0);
    rd(32'h20, 32'h1122CCDD);
    wr(32'h20, 4'h0, 32'hFFFFFFFF, 1'b0, '0);
    rd(32'h20, 32'h1122CCDD);
    rd(32'h1010, 32'hDEADBEEF);
    rd(32'h23, 32'h1122CCDD);
    wr(32'h50, 4'hF, 32'hCAFEF00D, 1'b0, '0);
    rd(32'h50, 32'hCAFEF00D);
    idle(3);
    chk("err_none_basic", 32'(err_seen), 32'd0);
    req(1'b1, 1'b1, 32'h40, 4'hF, 32'h12345678, 1'b0, '0, 32'h0);
    rd(32'h40, 32'h12345678);
    idle(3);
    chk("err_rw_collision", 32'(err_seen), 32'd1);

    // FIFO back-pressure: 6 back-to-back reads with resp_ready low
    for (int i = 0; i < 4; i++) wr(32'h200 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i), 1'b0, '0);
    bus.resp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      bus.read = 1'b1;
      bus.address = 32'h200 + 32'(4 * i);
      @(negedge clk);
      rdy = bus.request_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_q.push_back(32'hA0000000 + 32'(i));
        accepted++;
      end
    end
    bus.read = 1'b0;
    chk("fifo_accepted", 32'(accepted), 32'd4);
    @(negedge clk);
    chk("fifo_full_ready", 32'(bus.request_ready), 32'd0);
    chk("fifo_full_valid", 32'(bus.read_data_valid), 32'd1);
    @(posedge clk) #1 bus.resp_ready = 1'b1;
    @(posedge clk) #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_pop", 32'(bus.request_ready), 32'd1);
    chk("valid_after_pop", 32'(bus.read_data_valid), 32'd1);
    @(posedge clk) #1 bus.resp_ready = 1'b1;
    drain("drain_fifo");

    // Legal write burst and read-back
    wr(32'h100, 4'hF, 32'hB0B0B0B0, 1'b1, BW'(3));
    wr(32'h104, 4'hF, 32'hB1B1B1B1, 1'b0, BW'(2));
    wr(32'h108, 4'hF, 32'hB2B2B2B2, 1'b0, BW'(1));
    wr(32'h10C, 4'hF, 32'hB3B3B3B3, 1'b0, BW'(0));
    rd(32'h100, 32'hB0B0B0B0);
    rd(32'h104, 32'hB1B1B1B1);
    rd(32'h108, 32'hB2B2B2B2);
    rd(32'h10C, 32'hB3B3B3B3);
    req(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, BW'(0), 32'hB0B0B0B0);
    idle(3);
    chk("err_after_burst", 32'(err_seen), 32'd1);

    // Burst address violation
    wr(32'h300, 4'hF, 32'hC0C0C0C0, 1'b1, BW'(2));
    wr(32'h308, 4'hF, 32'hC8C8C8C8, 1'b0, BW'(1));
    @(negedge clk) chk("viol_pulse", 32'(protocol_err), 32'd1);
    @(negedge clk) chk("viol_pulse_end", 32'(protocol_err), 32'd0);
    @(posedge clk) #1;
    rd(32'h308, 32'hC8C8C8C8);
    rd(32'h300, 32'hC0C0C0C0);
    idle(3);
    chk("err_after_viol", 32'(err_seen), 32'd2);
    drain("drain_viol");

    // Reset mid read-burst with three responses queued
    bus.resp_ready = 1'b0;
    req(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, BW'(3), 32'hB0B0B0B0);
    req(1'b1, 1'b0, 32'h104, 4'h0, 32'h0, 1'b0, BW'(2), 32'hB1B1B1B1);
    req(1'b1, 1'b0, 32'h108, 4'h0, 32'h0, 1'b0, BW'(1), 32'hB2B2B2B2);
    idle(2);
    chk("pre_rst_valid", 32'(bus.read_data_valid), 32'd1);
    rest = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.read_data_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.request_ready), 32'd1);
    exp_q.delete();
    @(negedge clk) rest = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk) #1;
    rd(32'h10, 32'hDEADBEEF);
    rd(32'h104, 32'hB1B1B1B1);
    idle(3);
    drain("drain_final");
    chk("err_final", 32'(err_seen), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/avl_bus_ram_slave.md
Name: avl_bus_ram_slave

Overview:
- Synthesizable on-chip RAM slave on the avl_bus, sitting directly downstream of the slave port of the bus interconnect; it consumes the master-side request stream (single and burst) and produces read responses.
- It performs byte-enabled word writes and issues read data through a response FIFO that honours the master's resp_ready back-pressure.
- It tracks burst sequencing and flags protocol violations. It also serves as the reference slave for interconnect regression benches.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; power of two, ≥2. AW = $clog2(MEM_WORDS).
- RESP_FIFO_DEPTH, 4, read-response FIFO entries; power of two, ≥2.
- BURST_MAX, `ALV_BURST_MAX_COUNT, maximum burst_count value; burst_count width follows the bus definition.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rest  input  1  reset, asynchronous, active-low.
- avl_s  i_avl_bus.slave  -  bus slave modport. Members:
- avl_s.address  input  32  byte address; word index = address[AW+1:2]; upper bits and [1:0] ignored (window aliasing).
- avl_s.byte_en  input  4  write lane enables.
- avl_s.read / avl_s.write  input  1 each  request strobes.
- avl_s.write_data  input  32  write data.
- avl_s.begin_burst_transfer  input  1  first beat of a burst.
- avl_s.burst_count  input  bus width  remaining beats after the current one.
- avl_s.request_ready  output  1  request accepted at this edge if strobe high.
- avl_s.read_data  output  32  FIFO head data.
- avl_s.read_data_valid  output  1  FIFO non-empty.
- avl_s.resp_ready  input  1  master pops the head when valid.
- protocol_err  output  1  one-cycle pulse on a burst/strobe violation.

Behaviour:
- Reset (rest=0, async): FIFO empty, credit counter=0, burst FSM=IDLE, request_ready=1, read_data=0, read_data_valid=0, protocol_err=0. RAM contents are not cleared. Reset asserted mid-burst or with responses queued discards them with no further response.
- Accept: a beat is accepted at a posedge when (read|write)&&request_ready.
- request_ready = (credits < RESP_FIFO_DEPTH). It depends on registered state only, with no combinational path from read/write/resp_ready.
- Credits: +1 on accepted read, −1 on pop (resp_ready&&read_data_valid), unchanged when both occur. Credits never exceed RESP_FIFO_DEPTH, so the FIFO never overflows.
- Writes consume no credit but are also stalled while request_ready=0.
- Write: at the accept edge, each RAM byte lane i with byte_en[i]=1 takes write_data[8i+7:8i]. byte_en=0 is legal and performs a no-op write.
- Read: RAM is read at the accept edge; data is pushed into the FIFO at the next edge.
  - Accept at edge k gives read_data_valid=1 during cycle k+1 at the earliest; 1-cycle latency, no bypass.
  - Responses are returned in request order.
- Read-after-write: a write accepted at edge k followed by a read of the same word at k+1 returns the new data. A read and write accepted in the same cycle are impossible (see next point).
- read&&write both high: treated as a write, with no response and no credit, and protocol_err pulses.
- Pop: at an edge with resp_ready&&read_data_valid, the head is removed. Push and pop at the same edge on a full or empty FIFO are both legal.
- Burst FSM, IDLE:
  - Accepted beat with begin_burst_transfer=1 and burst_count≠0 → BURST.
  - Latch rem=burst_count, exp_addr=address+4, kind=read/write.
  - begin_burst_transfer with burst_count=0 is a single beat and the FSM stays in IDLE.
- Burst FSM, BURST, on each accepted beat, check all of the following:
  - begin_burst_transfer=0
  - same kind
  - address==exp_addr
  - burst_count==rem−1
- On pass: rem−1, exp_addr+4; when rem reaches 0 → IDLE.
- On fail: protocol_err pulses the next cycle and the FSM → IDLE, or restarts BURST if the violating beat has begin_burst_transfer=1 with burst_count≠0. The memory access is still performed.
- Idle cycles (no strobe) inside a burst are legal and do not advance the FSM.
- exp_addr wraps modulo 2^32. The word index wraps modulo MEM_WORDS.

Test Plan:
- Reset, write 0xDEADBEEF to 0x10 with byte_en=4'b1111, then read 0x10 → read_data_valid one cycle after accept, read_data=0xDEADBEEF, protocol_err stays 0.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD with byte_en=4'b0011 → read returns 0x1122CCDD. Write with byte_en=0 leaves it unchanged.
- resp_ready=0, 6 back-to-back reads, RESP_FIFO_DEPTH=4 → exactly 4 accepted and request_ready=0. Raising resp_ready for 1 cycle pops 1 beat, request_ready returns to 1, and order is preserved.
- Write burst at 0x100 with burst_count=3, then beats 0x104/0x108/0x10C with counts 2/1/0 → FSM returns to IDLE, read-back of 4 words is correct, no protocol_err.
- Burst started with burst_count=2, second beat at 0x108 instead of 0x104 → protocol_err pulse one cycle later, write still performed, FSM IDLE.
- Assert rest mid-burst with 3 reads queued → read_data_valid=0 and request_ready=1 immediately. RAM retains previously written data.
